// File: rtl/mor1kx_wb_arbiter_id.sv
// mor1kx_wb_arbiter_id: shares one 32-bit Wishbone B3 master port between the
// instruction-side (i_*) and data-side (d_*) bus bridges of a core.
// Arbitration happens per bus cycle, and the grant is held for the whole cycle,
// bursts included. Slave responses are routed back to the current owner only.
// A watchdog aborts cycles whose strobe stays unanswered for too long.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_*_i / i_*_o        instruction-side Wishbone slave interface
//   d_*_i / d_*_o        data-side Wishbone slave interface
//   m_*_o / m_*_i        shared Wishbone master interface
//   grant_o              {d,i} one-hot current owner, 00 when idle
//   timeout_o            one-cycle pulse when the watchdog aborts a cycle
//
// Parameters:
//   ARB_MODE             "RR" round-robin, "DPRIO" data side wins ties
//   TIMEOUT_WIDTH        watchdog counter width
//   TIMEOUT_CYCLES       stalled strobe cycles before abort, 0 disables
module mor1kx_wb_arbiter_id #(
  parameter string       ARB_MODE       = "RR",
  parameter int unsigned TIMEOUT_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction side
  input  logic [31:0] i_adr_i,
  input  logic [31:0] i_dat_i,
  input  logic        i_stb_i,
  input  logic        i_cyc_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_sel_i,
  input  logic [2:0]  i_cti_i,
  input  logic [1:0]  i_bte_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic        i_rty_o,
  output logic [31:0] i_dat_o,
  // data side
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic        d_stb_i,
  input  logic        d_cyc_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [2:0]  d_cti_i,
  input  logic [1:0]  d_bte_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic        d_rty_o,
  output logic [31:0] d_dat_o,
  // shared master port
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [2:0]  m_cti_o,
  output logic [1:0]  m_bte_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  input  logic [31:0] m_dat_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam bit PRIO_D = (ARB_MODE == "DPRIO");
  localparam bit WDT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value at which a still-unanswered strobe triggers the abort.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
    TIMEOUT_WIDTH'(WDT_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GNT_I,
    ST_GNT_D,
    ST_ABORT_I,
    ST_ABORT_D
  } state_e;

  state_e                   state_q, state_d;
  logic                     last_d_q, last_d_d;   // 1: data side served last
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     own_d;                // owner of a granted cycle is D
  logic                     resp;
  logic                     stall;
  logic                     to_hit;

  // State, round-robin history and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state, master-port mux, response routing and watchdog.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = '0;
    own_d     = 1'b0;
    resp      = 1'b0;
    stall     = 1'b0;
    to_hit    = 1'b0;
    m_adr_o   = '0;
    m_dat_o   = '0;
    m_stb_o   = 1'b0;
    m_cyc_o   = 1'b0;
    m_we_o    = 1'b0;
    m_sel_o   = '0;
    m_cti_o   = '0;
    m_bte_o   = '0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    i_rty_o   = 1'b0;
    i_dat_o   = '0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    d_rty_o   = 1'b0;
    d_dat_o   = '0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // On a tie, round-robin favours the side that was not served last.
        if (i_cyc_i && d_cyc_i) begin
          state_d = (PRIO_D || !last_d_q) ? ST_GNT_D : ST_GNT_I;
        end else if (d_cyc_i) begin
          state_d = ST_GNT_D;
        end else if (i_cyc_i) begin
          state_d = ST_GNT_I;
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        own_d   = (state_q == ST_GNT_D);
        grant_o = own_d ? 2'b10 : 2'b01;
        m_adr_o = own_d ? d_adr_i : i_adr_i;
        m_dat_o = own_d ? d_dat_i : i_dat_i;
        m_stb_o = own_d ? d_stb_i : i_stb_i;
        m_cyc_o = own_d ? d_cyc_i : i_cyc_i;
        m_we_o  = own_d ? d_we_i  : i_we_i;
        m_sel_o = own_d ? d_sel_i : i_sel_i;
        m_cti_o = own_d ? d_cti_i : i_cti_i;
        m_bte_o = own_d ? d_bte_i : i_bte_i;

        resp   = m_ack_i | m_err_i | m_rty_i;
        stall  = m_cyc_o & m_stb_o & ~resp;
        // A real response in the limit cycle wins over the watchdog.
        to_hit = WDT_EN && stall && (cnt_q == CNT_LAST);

        if (own_d) begin
          d_ack_o = m_ack_i;
          d_err_o = m_err_i | to_hit;
          d_rty_o = m_rty_i;
          d_dat_o = m_dat_i;
        end else begin
          i_ack_o = m_ack_i;
          i_err_o = m_err_i | to_hit;
          i_rty_o = m_rty_i;
          i_dat_o = m_dat_i;
        end
        timeout_o = to_hit;

        if (!m_cyc_o) begin
          state_d  = ST_IDLE;
          last_d_d = own_d;
        end else if (to_hit) begin
          state_d = own_d ? ST_ABORT_D : ST_ABORT_I;
        end else if (WDT_EN && stall) begin
          cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + TIMEOUT_WIDTH'(1);
        end
      end

      // Aborted cycle: bus released, late slave responses dropped.
      ST_ABORT_I: begin
        grant_o = 2'b01;
        if (!i_cyc_i) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b0;
        end
      end

      ST_ABORT_D: begin
        grant_o = 2'b10;
        if (!d_cyc_i) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
